// File: rtl/ex_muldiv_iter_if.sv
// rtl/ex_muldiv_iter_if.sv - EX-stage mul/div handshake bundle between pipeline and iterative unit
interface ex_muldiv_iter_if #(
    parameter int XLEN = 64
);
    logic            start_i;
    logic [3:0]      op_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            ex_stall_i;
    logic            flush_i;
    logic            busy_o;
    logic            result_valid_o;
    logic [XLEN-1:0] result_o;

    modport slave (
        input  start_i, op_i, src1_i, src2_i, ex_stall_i, flush_i,
        output busy_o, result_valid_o, result_o
    );

    modport master (
        output start_i, op_i, src1_i, src2_i, ex_stall_i, flush_i,
        input  busy_o, result_valid_o, result_o
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - radix-2 iterative multiply / restoring divide for the EX stage
// Optional MULDIV_FASTPATH_EN: div-by-zero, signed overflow and zero-operand multiplies finish in one cycle.
module ex_muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_muldiv_iter_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              dz_q, dz_d, ovf_q, ovf_d, mz_q, mz_d;

    // Operand decode at issue
    logic            in_w, in_div, in_a_signed, in_b_signed, in_sa, in_sb;
    logic            in_dz, in_ovf, in_mz, fast;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val;

    assign in_w        = bus.op_i[3];
    assign in_div      = bus.op_i[2];
    assign in_a_signed = in_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'd1 || bus.op_i[1:0] == 2'd2);
    assign in_b_signed = in_div ? ~bus.op_i[0] : (bus.op_i[1:0] == 2'd1);
    assign a_ext = in_w ? {{(XLEN-32){in_a_signed & bus.src1_i[31]}}, bus.src1_i[31:0]} : bus.src1_i;
    assign b_ext = in_w ? {{(XLEN-32){in_b_signed & bus.src2_i[31]}}, bus.src2_i[31:0]} : bus.src2_i;
    assign in_sa = in_a_signed & a_ext[XLEN-1];
    assign in_sb = in_b_signed & b_ext[XLEN-1];
    assign mag_a = in_sa ? -a_ext : a_ext;
    assign mag_b = in_sb ? -b_ext : b_ext;
    assign min_val = in_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign in_dz  = in_div & (b_ext == '0);
    assign in_ovf = in_div & ~bus.op_i[0] & (a_ext == min_val) & (b_ext == '1);
    assign in_mz  = ~in_div & ((a_ext == '0) | (b_ext == '0));

`ifdef MULDIV_FASTPATH_EN
    assign fast = in_dz | in_ovf | in_mz;
`else
    assign fast = 1'b0;
`endif

    // One iteration: multiply keeps {product_hi, multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN-1:0]   div_rem;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, opb_q};
    assign div_rem  = div_ge ? (div_sh[XLEN-1:0] - opb_q) : div_sh[XLEN-1:0];
    assign div_next = {div_rem, acc_q[XLEN-2:0], div_ge};

    // Result formatting from registered state only, so it holds while in DONE
    logic [2*XLEN-1:0] mul_full, mul_s;
    logic [XLEN-1:0]   mul_r, q_s, r_s, div_r, raw;

    assign mul_full = op_q[3] ? {{XLEN{1'b0}}, acc_q[2*XLEN-33:XLEN-32]} : acc_q;
    assign mul_s    = (sa_q ^ sb_q) ? -mul_full : mul_full;
    assign mul_r    = mz_q ? '0 : ((op_q[1:0] == 2'd0) ? mul_s[XLEN-1:0] : mul_s[2*XLEN-1:XLEN]);
    assign q_s      = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign r_s      = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign div_r    = dz_q  ? (op_q[1] ? a_q : '1) :
                      ovf_q ? (op_q[1] ? '0 : a_q) :
                      (op_q[1] ? r_s : q_s);
    assign raw      = op_q[2] ? div_r : mul_r;

    assign bus.result_o       = op_q[3] ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
    assign bus.result_valid_o = (state_q == S_DONE);
    assign bus.busy_o         = rst_n & bus.start_i & ~bus.result_valid_o & ~bus.flush_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        a_d     = a_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        mz_d    = mz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    op_d  = bus.op_i;
                    a_d   = a_ext;
                    sa_d  = in_sa;
                    sb_d  = in_sb;
                    dz_d  = in_dz;
                    ovf_d = in_ovf;
                    mz_d  = in_mz;
                    opb_d = in_div ? mag_b : mag_a;
                    if (in_div)
                        acc_d = {{XLEN{1'b0}}, (in_w ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a)};
                    else
                        acc_d = {{XLEN{1'b0}}, mag_b};
                    if (fast) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = in_w ? CW'(32) : CW'(XLEN);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!bus.start_i || bus.flush_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.start_i || bus.flush_i || !bus.ex_stall_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            a_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            mz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            a_q     <= a_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            mz_q    <= mz_d;
        end
    end
endmodule

// File: doc/ex_muldiv_iter.md
Name: ex_muldiv_iter

Overview:
- Iterative multiply/divide unit in the EX stage; one result bit per cycle (radix-2 shift-add / restoring divide).
- Raises the EX-stage mul/div stall request to the pipeline hazard controller for as long as a result is pending.
- Obeys that controller's outputs: its EX/MEM stall bit holds a finished result; its ID/EX flush bit cancels the operation in flight.

Parameters:
- XLEN, 64, datapath width; W-variants operate on the low 32 bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  a mul/div instruction occupies EX this cycle
- op_i  input  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW; bit3 = W
- src1_i  input  XLEN  rs1 operand
- src2_i  input  XLEN  rs2 operand
- ex_stall_i  input  1  EX/MEM stall bit from the controller (stall_o[4])
- flush_i  input  1  cancel request (controller flush_o[3] OR trap flush)
- busy_o  output  1  stall request to the controller (alu_mul_div_valid_ex_i)
- result_valid_o  output  1  result_o is final
- result_o  output  XLEN  product or quotient/remainder

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, counter 0, busy_o 0, result_valid_o 0, result_o 0. Reset mid-operation aborts with no result.
- busy_o = start_i & ~result_valid_o & ~flush_i (combinational), so the stall drops in the cycle the result is presented.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_i & ~flush_i: latch op and operands.
  - W ops: take the low 32 bits, sign- or zero-extended per op.
  - Signed ops: store operand magnitudes and the result sign.
  - Load counter = 64 (XLEN ops) or 32 (W ops); go to CALC.
- CALC:
  - One iteration per cycle; counter decrements.
  - When counter reaches 1, the next state is DONE.
  - Inputs are ignored after latch; src changes mid-op have no effect.
- DONE:
  - result_valid_o = 1 and result_o is held stable.
  - If ex_stall_i = 1, stay in DONE.
  - Otherwise go to IDLE; the EX/MEM register captures result_o on that edge.
- Cancel: flush_i high in any state, or start_i low in CALC/DONE → next state IDLE; the partial result is discarded and no valid is emitted.
- Latency, start to result_valid_o: 65 cycles for XLEN ops, 33 cycles for W ops. busy_o is high for exactly that many cycles.
- Back-to-back: a new start_i in the cycle after DONE→IDLE begins a new operation.
- Result rules:
  - MUL: low XLEN bits of the product.
  - MULH / MULHSU / MULHU: high XLEN bits with the respective signedness; the 2·XLEN product is negated if the sign is set.
  - DIV / REM: quotient truncates toward zero; the remainder takes the dividend's sign.
  - W ops: the 32-bit result is sign-extended to XLEN.
- Special cases (result mux, always applied):
  - Divide by zero: quotient all-ones, remainder = dividend (32-bit dividend for W).
  - Signed overflow (most-negative / −1): quotient = most-negative, remainder = 0.

Optional Feature:
- MULDIV_FASTPATH_EN defined:
  - Divide by zero, signed overflow, and any multiply with a zero operand go IDLE→DONE directly.
  - Latency is 1 cycle; busy_o is high for 1 cycle.
- Undefined:
  - These cases run the full iteration count.
  - The special-case result mux still yields identical values.

Test Plan:
- MUL, src1=7, src2=−3 (0xFFFF_FFFF_FFFF_FFFD) → busy_o high 65 cycles, result_o=0xFFFF_FFFF_FFFF_FFEB, result_valid_o one cycle.
- DIVW, src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → result_o=0xFFFF_FFFF_8000_0000 after 33 cycles.
- REMU, src1=100, src2=0 → result_o=100, quotient-path DIVU gives all-ones.
  - Fastpath defined: busy_o high 1 cycle.
  - Fastpath undefined: busy_o high 65 cycles.
- DIV, src1=−20, src2=6 with ex_stall_i held high 5 cycles at DONE → result_o=0xFFFF_FFFF_FFFF_FFFD held stable 6 cycles, then IDLE.
- MULHU in CALC, flush_i pulsed at cycle 10 → state IDLE next cycle, busy_o 0, no result_valid_o.
  - A new MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 then yields 1.
- rst_n asserted at cycle 20 of a DIV → outputs 0 immediately (asynchronous); after release, IDLE and accepts start_i.
